bcd_countdown_timer: RTL



---
 rtl/bcd_timer_pkg.sv | 25 ++
 rtl/bcd_down_digit.sv | 40 ++++
 rtl/bcd_countdown_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_timer_pkg
//   Shared definitions for the BCD countdown timer.
//   - BCD_MAX / BCD_ZERO : digit limits used by the down-counting digits
//   - timer_state_t      : control states of the timer
//   - clamp_digit()      : forces a preset digit into the legal 0..9 range
// ---------------------------------------------------------------------------
package bcd_timer_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    // Preset digits above 9 are not valid BCD; saturate them at 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
//   One BCD digit that counts downward, 9 -> 0 -> 9 with borrow.
//   Ports:
//     Clk        in   system clock, rising edge
//     Rst        in   synchronous active-high reset (digit -> 0)
//     Load       in   load the clamped preset digit
//     Valor      in   [3:0] preset digit
//     borrow_in  in   decrement request from the lower digit (or the tick)
//     Cuenta     out  [3:0] registered digit value
//     borrow_out out  decrement request for the next higher digit
// ---------------------------------------------------------------------------
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Load,
    input  logic [3:0] Valor,
    input  logic       borrow_in,
    output logic [3:0] Cuenta,
    output logic       borrow_out
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Cuenta <= BCD_ZERO;
        end else if (Load) begin
            Cuenta <= clamp_digit(Valor);
        end else if (borrow_in) begin
            Cuenta <= (Cuenta == BCD_ZERO) ? BCD_MAX : Cuenta - 4'd1;
        end
    end

    // A digit sitting at zero passes the decrement on to the next digit.
    assign borrow_out = borrow_in & (Cuenta == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   Multi-digit BCD down-counter. A preset is loaded, then the count is
//   decremented once every TICK_DIV clocks while running; a one-cycle Done
//   pulse accompanies the decrement that reaches zero.
//   Parameters:
//     DIGITS    number of BCD digits (1..8)
//     TICK_DIV  clocks per decrement (>= 1)
//   Ports:
//     Clk      in   system clock, rising edge
//     Rst      in   synchronous active-high reset
//     Load     in   load Valor (clamped per digit), go to IDLE
//     Start    in   start / resume counting
//     Stop     in   pause counting
//     Valor    in   [4*DIGITS-1:0] BCD preset, digit 0 in bits [3:0]
//     Cuenta   out  [4*DIGITS-1:0] registered BCD count
//     Running  out  high while in RUN
//     Zero     out  combinational, Cuenta == 0
//     Done     out  one-cycle pulse when the count expires
//   Control priority: Rst > Load > Stop > Start.
// ---------------------------------------------------------------------------
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Load,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic [4*DIGITS-1:0]   Valor,
    output logic [4*DIGITS-1:0]   Cuenta,
    output logic                  Running,
    output logic                  Zero,
    output logic                  Done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    timer_state_t   state;
    timer_state_t   state_next;
    logic [PW-1:0]  prescaler;
    logic           advance;
    logic           tick;
    logic           cnt_is_one;
    logic           expire;
    logic [3:0]     digit_q [DIGITS];
    wire  [DIGITS:0] borrow;

    // The prescaler only moves in RUN, and Load/Stop take precedence over the
    // tick, so a stopped or reloaded timer never decrements on that edge.
    assign advance    = (state == RUN) && !Load && !Stop;
    assign tick       = advance && (prescaler == PRE_LAST);
    assign cnt_is_one = (Cuenta == W'(1));
    // A borrow out of the top digit would mean the count underflowed; treat it
    // as expiry as well so the timer can never keep running through all-9s.
    assign expire     = tick && (cnt_is_one || borrow[DIGITS]);

    assign borrow[0] = tick;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .Clk        (Clk),
            .Rst        (Rst),
            .Load       (Load),
            .Valor      (Valor[4*i +: 4]),
            .borrow_in  (borrow[i]),
            .Cuenta     (digit_q[i]),
            .borrow_out (borrow[i+1])
        );
    end

    always_comb begin
        Cuenta = '0;
        for (int i = 0; i < DIGITS; i++) begin
            Cuenta[4*i +: 4] = digit_q[i];
        end
    end

    assign Zero    = (Cuenta == '0);
    assign Running = (state == RUN);

    // Prescaler: cleared by reset and load, held in PAUSE (Stop does not clear
    // it), wraps to zero on the tick.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prescaler <= '0;
        end else if (Load) begin
            prescaler <= '0;
        end else if (advance) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    // Done is registered alongside the final decrement, so it is high in
    // exactly the cycle in which Cuenta first reads zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Done <= 1'b0;
        end else begin
            Done <= expire;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before any branch so no path through
    // this block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (Load) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE, PAUSE: begin
                    if (!Stop && Start && !Zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state_next = PAUSE;
                    end else if (expire) begin
                        state_next = EXPIRED;
                    end
                end
                EXPIRED: begin
                    state_next = EXPIRED;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
